// File: rtl/lcd_pkg.sv
// Shared types for the LCD panel command/stream sequencer: opcodes, FSM states
// and the command-ROM entry format.
package lcd_pkg;

   localparam logic [7:0] CMD_SWRESET = 8'h01;
   localparam logic [7:0] CMD_SLPOUT  = 8'h11;
   localparam logic [7:0] CMD_COLMOD  = 8'h3A;
   localparam logic [7:0] CMD_MADCTL  = 8'h36;
   localparam logic [7:0] CMD_INVON   = 8'h21;
   localparam logic [7:0] CMD_NORON   = 8'h13;
   localparam logic [7:0] CMD_DISPON  = 8'h29;
   localparam logic [7:0] CMD_CASET   = 8'h2A;
   localparam logic [7:0] CMD_RASET   = 8'h2B;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;

   localparam logic [7:0] COLMOD_16BPP = 8'h55;
   localparam logic [7:0] MADCTL_DEF   = 8'h00;

   localparam logic [6:0] LAST_WORD = 7'd127;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE,
      DELAY,
      STREAM_WAIT,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      ACT_NONE,
      ACT_INIT,
      ACT_PX,
      ACT_STREAM
   } action_t;

   typedef struct packed {
      logic        dc;
      logic        wide;
      logic        delay_after;
      logic        last;
      logic [31:0] data;
   } seq_entry_t;

   function automatic seq_entry_t cmd_entry(input logic [7:0] op, input logic dly,
                                            input logic last);
      return '{dc: 1'b0, wide: 1'b0, delay_after: dly, last: last, data: {24'd0, op}};
   endfunction

   function automatic seq_entry_t data_entry(input logic [31:0] d, input logic wide,
                                             input logic last);
      return '{dc: 1'b1, wide: wide, delay_after: 1'b0, last: last, data: d};
   endfunction

endpackage

// File: rtl/lcd_if_if.sv
// SPI-front side of the LCD sequencer: transfer word, width, D/C, start pulse,
// busy return and chip select. master = sequencer, slave = spi_front.
interface lcd_if_if;
   logic [31:0] spi_mosi;
   logic        spi_begin;
   logic        spi_wide;
   logic        spi_busy;
   logic        spi_cs;
   logic        lcd_data_cmd;

   modport master (
      output spi_mosi, spi_begin, spi_wide, spi_cs, lcd_data_cmd,
      input  spi_busy
   );

   modport slave (
      input  spi_mosi, spi_begin, spi_wide, spi_cs, lcd_data_cmd,
      output spi_busy
   );
endinterface

// File: rtl/lcd_cmd_rom.sv
// Step index -> sequence entry for the panel init and pixel-window command
// sequences. Purely combinational.
module lcd_cmd_rom
   import lcd_pkg::*;
#(
   parameter int RES = 240
) (
   input  action_t    sel,
   input  logic [3:0] step,
   output seq_entry_t entry
);

   localparam logic [31:0] END_ADDR = {16'd0, 16'(RES - 1)};

   always_comb begin
      entry = '0;
      if (sel == ACT_PX) begin
         case (step)
            4'd0:    entry = cmd_entry(CMD_CASET, 1'b0, 1'b0);
            4'd1:    entry = data_entry(END_ADDR, 1'b1, 1'b0);
            4'd2:    entry = cmd_entry(CMD_RASET, 1'b0, 1'b0);
            4'd3:    entry = data_entry(END_ADDR, 1'b1, 1'b0);
            4'd4:    entry = cmd_entry(CMD_RAMWR, 1'b0, 1'b1);
            default: entry = '0;
         endcase
      end else begin
         case (step)
            4'd0:    entry = cmd_entry(CMD_SWRESET, 1'b1, 1'b0);
            4'd1:    entry = cmd_entry(CMD_SLPOUT, 1'b1, 1'b0);
            4'd2:    entry = cmd_entry(CMD_COLMOD, 1'b0, 1'b0);
            4'd3:    entry = data_entry({24'd0, COLMOD_16BPP}, 1'b0, 1'b0);
            4'd4:    entry = cmd_entry(CMD_MADCTL, 1'b0, 1'b0);
            4'd5:    entry = data_entry({24'd0, MADCTL_DEF}, 1'b0, 1'b0);
            4'd6:    entry = cmd_entry(CMD_INVON, 1'b0, 1'b0);
            4'd7:    entry = cmd_entry(CMD_NORON, 1'b0, 1'b0);
            4'd8:    entry = cmd_entry(CMD_DISPON, 1'b0, 1'b1);
            default: entry = '0;
         endcase
      end
   end

endmodule

// File: rtl/lcd_if.sv
// LCD panel sequencer: runs init / pixel-window command sequences from a ROM,
// or streams 128 host words, driving one spi_front transfer at a time.
module lcd_if
   import lcd_pkg::*;
#(
   parameter int RES          = 240,
   parameter int DELAY_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init,
   input  logic              px_stream_cmd,
   input  logic              stream_512B,
   input  logic              if_begin,
   output logic              if_busy,
   input  logic [31:0]       stream_data,
   input  logic              stream_trigger,
   output logic              stream_busy,
   lcd_if_if.master          spi,
   output state_t            fsm_state
);

   // Handshake to spi_front: transfer fields are held in cur_q from ISSUE until
   // the transfer retires; spi_begin is high only in ISSUE; spi_busy is ignored
   // for one cycle (WAIT_ACK) and the transfer retires when it is then seen low.

   state_t     state_q, state_d;
   action_t    act_q, act_d;
   logic [3:0] step_q, step_d;
   logic [6:0] cnt_q, cnt_d;
   logic [31:0] dly_q, dly_d;
   seq_entry_t cur_q;
   seq_entry_t rom_entry;
   logic       load_rom, load_stream, advance;

   lcd_cmd_rom #(.RES(RES)) u_rom (
      .sel   (act_d),
      .step  (step_d),
      .entry (rom_entry)
   );

   always_comb begin
      state_d     = state_q;
      act_d       = act_q;
      step_d      = step_q;
      cnt_d       = cnt_q;
      dly_d       = dly_q;
      load_rom    = 1'b0;
      load_stream = 1'b0;
      advance     = 1'b0;
      case (state_q)
         IDLE: begin
            if (if_begin) begin
               if (init) begin
                  act_d    = ACT_INIT;
                  state_d  = ISSUE;
                  load_rom = 1'b1;
               end else if (px_stream_cmd) begin
                  act_d    = ACT_PX;
                  state_d  = ISSUE;
                  load_rom = 1'b1;
               end else if (stream_512B) begin
                  act_d   = ACT_STREAM;
                  state_d = STREAM_WAIT;
               end
            end
         end
         ISSUE:    state_d = WAIT_ACK;
         WAIT_ACK: state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (!spi.spi_busy) begin
               if (act_q == ACT_STREAM) begin
                  if (cnt_q == LAST_WORD) begin
                     state_d = DONE;
                  end else begin
                     cnt_d   = cnt_q + 7'd1;
                     state_d = STREAM_WAIT;
                  end
               end else if (cur_q.delay_after) begin
                  dly_d   = '0;
                  state_d = DELAY;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         DELAY: begin
            if (dly_q == 32'(DELAY_CYCLES - 1)) advance = 1'b1;
            else dly_d = dly_q + 32'd1;
         end
         STREAM_WAIT: begin
            if (stream_trigger) begin
               load_stream = 1'b1;
               state_d     = ISSUE;
            end
         end
         DONE: begin
            state_d = IDLE;
            act_d   = ACT_NONE;
            step_d  = '0;
            cnt_d   = '0;
            dly_d   = '0;
         end
         default: state_d = IDLE;
      endcase

      if (advance) begin
         if (cur_q.last) begin
            state_d = DONE;
         end else begin
            step_d   = step_q + 4'd1;
            load_rom = 1'b1;
            state_d  = ISSUE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         act_q   <= ACT_NONE;
         step_q  <= '0;
         cnt_q   <= '0;
         dly_q   <= '0;
         cur_q   <= '0;
      end else begin
         state_q <= state_d;
         act_q   <= act_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         dly_q   <= dly_d;
         if (load_rom) begin
            cur_q <= rom_entry;
         end else if (load_stream) begin
            cur_q <= '{dc: 1'b1, wide: 1'b1, delay_after: 1'b0, last: 1'b0,
                       data: stream_data};
         end
      end
   end

   assign if_busy          = (state_q != IDLE) && (state_q != DONE);
   assign stream_busy      = (act_q == ACT_STREAM) &&
                             (state_q inside {ISSUE, WAIT_ACK, WAIT_DONE});
   assign spi.spi_cs       = !if_busy;
   assign spi.spi_begin    = (state_q == ISSUE);
   assign spi.spi_mosi     = cur_q.data;
   assign spi.spi_wide     = cur_q.wide;
   assign spi.lcd_data_cmd = cur_q.dc;
   assign fsm_state        = state_q;

endmodule

// File: tb/tb_lcd_if.sv
// Directed bench for lcd_if: init, pixel-window and 512 B stream actions,
// ignored requests while busy, and reset in the middle of init.
module tb_lcd_if;
   import lcd_pkg::*;

   localparam int RES = 240;
   localparam int DLY = 16;
   localparam int W   = 34;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        init = 1'b0;
   logic        px_stream_cmd = 1'b0;
   logic        stream_512B = 1'b0;
   logic        if_begin = 1'b0;
   logic        stream_trigger = 1'b0;
   logic [31:0] stream_data = '0;
   logic        if_busy;
   logic        stream_busy;
   state_t      fsm_state;

   lcd_if_if bus ();

   lcd_if #(.RES(RES), .DELAY_CYCLES(DLY)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .init           (init),
      .px_stream_cmd  (px_stream_cmd),
      .stream_512B    (stream_512B),
      .if_begin       (if_begin),
      .if_busy        (if_busy),
      .stream_data    (stream_data),
      .stream_trigger (stream_trigger),
      .stream_busy    (stream_busy),
      .spi            (bus),
      .fsm_state      (fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // spi_front model: busy rises the cycle after spi_begin, lasts 3 cycles
   logic [2:0] busy_cnt = 3'd0;
   always @(posedge clk) begin
      if (bus.spi_begin) busy_cnt <= 3'd3;
      else if (busy_cnt != 3'd0) busy_cnt <= busy_cnt - 3'd1;
   end
   assign bus.spi_busy = (busy_cnt != 3'd0);

   // scoreboard
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int unstable = 0;
   int cs_high_at_begin = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];
   int beg_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && bus.spi_begin) begin
         obs_q.push_back({bus.lcd_data_cmd, bus.spi_wide, bus.spi_mosi});
         beg_cyc.push_back(cyc);
         if (bus.spi_cs) cs_high_at_begin++;
      end else if (rst_n && if_busy && busy_cnt != 3'd0 && obs_q.size() > 0) begin
         if ({bus.lcd_data_cmd, bus.spi_wide, bus.spi_mosi} != obs_q[obs_q.size()-1])
            unstable++;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic exp_push(input logic dc, input logic wide, input logic [31:0] d);
      exp_q.push_back({dc, wide, d});
   endtask

   task automatic push_init_exp();
      exp_push(1'b0, 1'b0, 32'h01);
      exp_push(1'b0, 1'b0, 32'h11);
      exp_push(1'b0, 1'b0, 32'h3A);
      exp_push(1'b1, 1'b0, 32'h55);
      exp_push(1'b0, 1'b0, 32'h36);
      exp_push(1'b1, 1'b0, 32'h00);
      exp_push(1'b0, 1'b0, 32'h21);
      exp_push(1'b0, 1'b0, 32'h13);
      exp_push(1'b0, 1'b0, 32'h29);
   endtask

   task automatic start_action(input logic i, input logic p, input logic s);
      @(posedge clk);
      #1;
      init = i;
      px_stream_cmd = p;
      stream_512B = s;
      if_begin = 1'b1;
      @(posedge clk);
      #1;
      if_begin = 1'b0;
      init = 1'b0;
      px_stream_cmd = 1'b0;
      stream_512B = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int max);
      int n;
      n = 0;
      @(negedge clk);
      while (if_busy && n < max) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_busy_released"}, 64'(if_busy), 64'd0);
      check({tag, "_cs_released"}, 64'(bus.spi_cs), 64'd1);
   endtask

   task automatic compare_transfers(input string tag);
      int n;
      check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int k = 0; k < n; k++) check($sformatf("%s_xfer%0d", tag, k), 64'(obs_q[k]), 64'(exp_q[k]));
      obs_q.delete();
      exp_q.delete();
      beg_cyc.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_if_busy"}, 64'(if_busy), 64'd0);
      check({tag, "_stream_busy"}, 64'(stream_busy), 64'd0);
      check({tag, "_spi_begin"}, 64'(bus.spi_begin), 64'd0);
      check({tag, "_spi_wide"}, 64'(bus.spi_wide), 64'd0);
      check({tag, "_spi_mosi"}, 64'(bus.spi_mosi), 64'd0);
      check({tag, "_dc"}, 64'(bus.lcd_data_cmd), 64'd0);
      check({tag, "_spi_cs"}, 64'(bus.spi_cs), 64'd1);
      check({tag, "_state"}, 64'(fsm_state), 64'(IDLE));
   endtask

   task automatic stream_word(input logic [31:0] d, input logic poke_busy);
      int n;
      n = 0;
      @(negedge clk);
      while (stream_busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("stream_ready_timeout", 64'(stream_busy), 64'd0);
      stream_data = d;
      stream_trigger = 1'b1;
      @(posedge clk);
      #1;
      if (poke_busy) begin
         // retrigger while the word is in flight; must be dropped
         stream_data = 32'hDEAD_BEEF;
         @(posedge clk);
         #1;
      end
      stream_trigger = 1'b0;
   endtask

   initial begin
      int g;
      int n;

      // reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // if_begin with no action selected
      start_action(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("nosel_busy", 64'(if_busy), 64'd0);
      check("nosel_cs", 64'(bus.spi_cs), 64'd1);

      // stream_trigger outside a stream action
      @(posedge clk);
      #1 stream_trigger = 1'b1;
      @(posedge clk);
      #1 stream_trigger = 1'b0;
      repeat (6) @(negedge clk);
      check("idle_xfers", 64'(obs_q.size()), 64'd0);

      // init sequence, with a second request and a stray trigger while busy
      push_init_exp();
      start_action(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("init_busy", 64'(if_busy), 64'd1);
      check("init_cs_low", 64'(bus.spi_cs), 64'd0);
      @(posedge clk);
      #1;
      px_stream_cmd = 1'b1;
      if_begin = 1'b1;
      stream_trigger = 1'b1;
      @(posedge clk);
      #1;
      px_stream_cmd = 1'b0;
      if_begin = 1'b0;
      stream_trigger = 1'b0;
      wait_idle("init", 2000);
      g = (beg_cyc.size() >= 3) ? beg_cyc[1] - beg_cyc[0] : 0;
      check("init_gap_after_01", 64'(g >= DLY + 2), 64'd1);
      g = (beg_cyc.size() >= 3) ? beg_cyc[2] - beg_cyc[1] : 0;
      check("init_gap_after_11", 64'(g >= DLY + 2), 64'd1);
      compare_transfers("init");

      // pixel window commands; px_stream_cmd outranks stream_512B
      exp_push(1'b0, 1'b0, 32'h2A);
      exp_push(1'b1, 1'b1, 32'h0000_00EF);
      exp_push(1'b0, 1'b0, 32'h2B);
      exp_push(1'b1, 1'b1, 32'h0000_00EF);
      exp_push(1'b0, 1'b0, 32'h2C);
      start_action(1'b0, 1'b1, 1'b1);
      @(negedge clk);
      check("px_busy", 64'(if_busy), 64'd1);
      check("px_stream_busy", 64'(stream_busy), 64'd0);
      wait_idle("px", 2000);
      compare_transfers("px");

      // 512 B stream
      start_action(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("stream_busy_if", 64'(if_busy), 64'd1);
      check("stream_cs_low", 64'(bus.spi_cs), 64'd0);
      check("stream_idle_wait", 64'(stream_busy), 64'd0);
      for (int k = 0; k < 128; k++) begin
         exp_push(1'b1, 1'b1, 32'h55AA_E621);
         stream_word(32'h55AA_E621, (k == 5) || (k == 127));
         if (k == 0) begin
            @(negedge clk);
            check("stream_busy_inflight", 64'(stream_busy), 64'd1);
         end
         if (k == 126) begin
            @(negedge clk);
            check("stream_busy_before_last", 64'(if_busy), 64'd1);
         end
      end
      wait_idle("stream", 2000);
      check("stream_busy_after", 64'(stream_busy), 64'd0);
      compare_transfers("stream");

      // reset during init's third transfer, then a fresh init
      start_action(1'b1, 1'b0, 1'b0);
      n = 0;
      while (obs_q.size() < 3 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("midrst_reached_3rd", 64'(obs_q.size()), 64'd3);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("midrst_no_resume", 64'(obs_q.size()), 64'd3);
      obs_q.delete();
      beg_cyc.delete();

      push_init_exp();
      start_action(1'b1, 1'b1, 1'b1);
      wait_idle("reinit", 2000);
      compare_transfers("reinit");

      check("outputs_stable", 64'(unstable), 64'd0);
      check("cs_low_at_begin", 64'(cs_high_at_begin), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
